umips_pipe_stage: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, flush, and a NOP payload on empty slots. It sits between any two umips pipeline stages, e.g. fetch→decode carrying {pc_plus_4, inst}. It replaces the fixed-width stall/flush register. An optional 2-entry skid buffer registers `in_ready` so backpressure never forms a combinational path through the stage.

---
 rtl/umips_pipe_stage.sv | 121 ++++++++++++
 tb/tb_umips_pipe_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/umips_pipe_stage.sv
// umips_pipe_stage: valid/ready pipeline register with flush and NOP fill on empty slots.
// Define UMIPS_PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module umips_pipe_stage #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
`ifdef UMIPS_PIPE_SKID_EN
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
`else
        ST_ONE   = 2'd1
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
`ifdef UMIPS_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
`endif

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Output decode; main holds NOP_VALUE whenever the stage is empty.
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

`ifdef UMIPS_PIPE_SKID_EN
    assign in_ready = (state_q != ST_TWO);
    assign count    = 2'(state_q);
`else
    assign in_ready = ~out_valid | out_ready;
    assign count    = {1'b0, (state_q == ST_ONE)};
`endif

    // Next-state and storage update; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef UMIPS_PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
`ifdef UMIPS_PIPE_SKID_EN
            skid_d  = NOP_VALUE;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef UMIPS_PIPE_SKID_EN
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
`endif
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
`ifdef UMIPS_PIPE_SKID_EN
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
`ifdef UMIPS_PIPE_SKID_EN
            skid_q  <= NOP_VALUE;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef UMIPS_PIPE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: tb/tb_umips_pipe_stage.sv
// Self-checking bench for umips_pipe_stage against a queue model of the stage.
// Follows UMIPS_PIPE_SKID_EN to select 2-entry or 1-entry expectations.
module tb_umips_pipe_stage;

    localparam int unsigned  W   = 64;
    localparam logic [W-1:0] NOP = '0;
`ifdef UMIPS_PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic         clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   count;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] mq[$];

    umips_pipe_stage #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a FIFO of capacity DEPTH; the skid build only looks at its fill level.
    function automatic logic m_in_ready();
        if (DEPTH == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic logic [W-1:0] m_head();
        return (mq.size() != 0) ? mq[0] : NOP;
    endfunction

    task automatic tick();
        logic acc, pop;
        acc = in_valid && m_in_ready();
        pop = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== NOP) begin n_err++; $display("FAIL rst_out_data: got %h expected %h", out_data, NOP); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 64'(64'hA0 + i);
            tick();
        end
        in_data = 64'hEE;
        @(negedge clk);
        n_cmp++; if (count !== 2'(DEPTH)) begin n_err++; $display("FAIL rst_fill_count: got %0d expected %0d", count, DEPTH); end
        #2 rst = 1'b0;
        #1 mq.delete();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== NOP) begin n_err++; $display("FAIL rst_mid_out_data: got %h expected %h", out_data, NOP); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; flush = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick(); #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
                n_err++; $display("FAIL stream_data[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, 64'(i));
            end
            n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
        end
        in_valid = 1'b0;
        tick(); #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== NOP) begin
            n_err++; $display("FAIL stream_drain: got v=%b %h expected v=0 %h", out_valid, out_data, NOP);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] items[3];
        logic [W-1:0] got[$];
        int idx;
        items[0] = 64'hA; items[1] = 64'hB; items[2] = 64'hC;
        idx = 0; out_ready = 1'b0; flush = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 4) out_ready = 1'b1;
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? items[idx] : NOP;
            @(negedge clk);
            n_cmp++; if (in_ready !== m_in_ready()) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", cyc, in_ready, m_in_ready()); end
            n_cmp++; if (count !== 2'(mq.size())) begin n_err++; $display("FAIL bp_count[%0d]: got %0d expected %0d", cyc, count, mq.size()); end
`ifdef UMIPS_PIPE_SKID_EN
            if (cyc == 2 || cyc == 3) begin
                n_cmp++; if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'hA) begin
                    n_err++; $display("FAIL bp_skid_full[%0d]: got cnt=%0d rdy=%b %h expected cnt=2 rdy=0 a", cyc, count, in_ready, out_data);
                end
            end
            if (cyc == 5) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_return: got %b expected 1", in_ready); end
            end
`endif
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && m_in_ready()) idx++;
            tick();
        end
        n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_delivered_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_cmp++; if (got[i] !== items[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], items[i]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 64'(64'h11 * (i + 1));
            tick();
        end
        in_valid = 1'b1; in_data = 64'h33; flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (count !== 2'(DEPTH)) begin n_err++; $display("FAIL flush_pre_count: got %0d expected %0d", count, DEPTH); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== NOP) begin
            n_err++; $display("FAIL flush_empty: got v=%b cnt=%0d %h expected v=0 cnt=0 %h", out_valid, count, out_data, NOP);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0 || out_data === 64'h33) begin
                n_err++; $display("FAIL flush_ghost[%0d]: got v=%b %h expected v=0 %h", i, out_valid, out_data, NOP);
            end
            tick();
        end
    endtask

    task automatic test_flush_ofire();
        int seen;
        seen = 0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h44;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        if (out_valid && out_data === 64'h44) seen++;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ofire_empty[%0d]: got %b expected 0", i, out_valid); end
            if (out_valid && out_data === 64'h44) seen++;
            tick();
        end
        n_cmp++; if (seen != 1) begin n_err++; $display("FAIL flush_ofire_once: got %0d expected 1", seen); end
    endtask

`ifndef UMIPS_PIPE_SKID_EN
    task automatic test_noskid();
        flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h55;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || count !== 2'd1) begin n_err++; $display("FAIL noskid_hold: got v=%b cnt=%0d expected v=1 cnt=1", out_valid, count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL noskid_stall_ready: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL noskid_comb_ready: got %b expected 1", in_ready); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic pend;
        pend = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom(), $urandom()};
            end
            out_ready = ((c % 200) < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, mq.size() != 0); end
            n_cmp++; if (out_data !== m_head()) begin n_err++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, out_data, m_head()); end
            n_cmp++; if (count !== 2'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
            n_cmp++; if (in_ready !== m_in_ready()) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, in_ready, m_in_ready()); end
            if (!out_valid) begin
                n_cmp++; if (out_data !== NOP) begin n_err++; $display("FAIL rnd_nop[%0d]: got %h expected %h", c, out_data, NOP); end
            end
            pend = in_valid && !m_in_ready() && !flush;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_ofire();
`ifndef UMIPS_PIPE_SKID_EN
        test_noskid();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
